// File: rtl/syn_pkg.sv
// Shared types and default frame timing for the master sync-line scheduler
// and the slave sync receivers that decode its frames.
package syn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } syn_state_t;

  localparam logic [2:0] OWNER_SYNC = 3'd7;
  localparam int         PAYLOAD_W  = 8;

  localparam int DEF_PRE_CYC   = 3;
  localparam int DEF_BIT_CYC   = 5;
  localparam int DEF_GUARD_CYC = 10;
  localparam int DEF_SEC_DIV   = 10000000;

endpackage

// File: rtl/syn_rr_arb.sv
// Combinational round-robin priority encoder: the first asserted request at
// or above ptr wins, otherwise the lowest asserted request wraps around.
module syn_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] upper_req;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign upper_req[gi] = req[gi] && (IW'(gi) >= ptr);
    end
  endgenerate

  // Scanning high to low leaves the lowest set index in idx.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    if (|upper_req) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (upper_req[i]) idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/syn_tx_sched.sv
// Sync-line scheduler: arbitrates requesters and the seconds broadcast, then
// serialises one byte as preamble, 8 MSB-first bits and a low guard period.
module syn_tx_sched
  import syn_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int PRE_CYC   = DEF_PRE_CYC,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int SEC_DIV   = DEF_SEC_DIV
) (
  input  logic                   clk_10M,
  input  logic                   rst_n,
  input  logic                   sync_en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*8-1:0]      req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   data_to_slave,
  output logic                   busy,
  output logic                   frame_done,
  output logic [2:0]             owner,
  output logic [7:0]             sec_cnt,
  output logic                   sync_drop
);

  localparam int IW = $clog2(NREQ);
  // Timing parameters must each lie in 1..255 to fit the phase counter.
  localparam logic [7:0]  PRE_LAST   = 8'(PRE_CYC - 1);
  localparam logic [7:0]  BIT_LAST   = 8'(BIT_CYC - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYC - 1);
  localparam logic [23:0] TICK_LAST  = 24'(SEC_DIV - 1);

  syn_state_t             state_reg;
  logic [PAYLOAD_W-1:0]   shift_reg;
  logic [7:0]             phase_reg;
  logic [2:0]             bit_cnt_reg;
  logic [IW-1:0]          ptr_reg;
  logic [23:0]            tick_reg;
  logic                   sync_pend_reg;

  logic                   arb_valid;
  logic [IW-1:0]          arb_idx;
  logic [IW-1:0]          ptr_next;
  logic                   tick_wrap;
  logic                   sync_take;
  logic [PAYLOAD_W-1:0]   req_bytes [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*8 +: 8];
    end
  endgenerate

  syn_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  assign ptr_next  = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
  assign tick_wrap = sync_en && (tick_reg == TICK_LAST);
  assign sync_take = (state_reg == IDLE) && sync_pend_reg;

  // A second tick while a broadcast is still waiting is reported, not queued.
  always_ff @(posedge clk_10M or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg      <= '0;
      sync_pend_reg <= 1'b0;
      sec_cnt       <= '0;
      sync_drop     <= 1'b0;
    end else begin
      sync_drop <= 1'b0;
      if (!sync_en) begin
        tick_reg      <= '0;
        sync_pend_reg <= 1'b0;
      end else if (tick_wrap) begin
        tick_reg      <= '0;
        sec_cnt       <= sec_cnt + 8'd1;
        sync_pend_reg <= 1'b1;
        sync_drop     <= sync_pend_reg;
      end else begin
        tick_reg <= tick_reg + 24'd1;
        if (sync_take) sync_pend_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_10M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      phase_reg     <= '0;
      bit_cnt_reg   <= '0;
      ptr_reg       <= '0;
      gnt           <= '0;
      data_to_slave <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      owner         <= '0;
    end else begin
      gnt        <= '0;
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          phase_reg   <= '0;
          bit_cnt_reg <= '0;
          if (sync_pend_reg) begin
            state_reg     <= PRE;
            shift_reg     <= sec_cnt;
            owner         <= OWNER_SYNC;
            data_to_slave <= 1'b1;
            busy          <= 1'b1;
          end else if (arb_valid) begin
            state_reg     <= PRE;
            shift_reg     <= req_bytes[arb_idx];
            owner         <= 3'(arb_idx);
            gnt[arb_idx]  <= 1'b1;
            ptr_reg       <= ptr_next;
            data_to_slave <= 1'b1;
            busy          <= 1'b1;
          end else begin
            data_to_slave <= 1'b0;
          end
        end
        PRE: begin
          if (phase_reg == PRE_LAST) begin
            state_reg     <= DATA;
            phase_reg     <= '0;
            data_to_slave <= shift_reg[7];
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        DATA: begin
          if (phase_reg == BIT_LAST) begin
            phase_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              state_reg     <= GUARD;
              data_to_slave <= 1'b0;
            end else begin
              bit_cnt_reg   <= bit_cnt_reg + 3'd1;
              shift_reg     <= {shift_reg[6:0], 1'b0};
              data_to_slave <= shift_reg[6];
            end
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        GUARD: begin
          data_to_slave <= 1'b0;
          if (phase_reg == GUARD_LAST) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_tx_sched.sv
// Bench for syn_tx_sched: a frame-position model checked every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_syn_tx_sched;
  import syn_pkg::*;

  localparam int NREQ  = 4;
  localparam int PRE   = 3;
  localparam int BITC  = 5;
  localparam int GUARD = 10;
  localparam int SEC   = 40;
  localparam int FRAME = PRE + 8 * BITC + GUARD;

  logic                 clk_10M = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 sync_en = 1'b0;
  logic [NREQ-1:0]      req     = '0;
  logic [NREQ*8-1:0]    req_data = '0;
  logic [NREQ-1:0]      gnt;
  logic                 data_to_slave;
  logic                 busy;
  logic                 frame_done;
  logic [2:0]           owner;
  logic [7:0]           sec_cnt;
  logic                 sync_drop;

  always #50 clk_10M = ~clk_10M;

  syn_tx_sched #(
    .NREQ(NREQ), .PRE_CYC(PRE), .BIT_CYC(BITC), .GUARD_CYC(GUARD), .SEC_DIV(SEC)
  ) dut (
    .clk_10M       (clk_10M),
    .rst_n         (rst_n),
    .sync_en       (sync_en),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .data_to_slave (data_to_slave),
    .busy          (busy),
    .frame_done    (frame_done),
    .owner         (owner),
    .sec_cnt       (sec_cnt),
    .sync_drop     (sync_drop)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_drop_obs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a position 0..FRAME-1 plus a payload byte.
  bit              m_active, m_pend, m_drop, m_done;
  int              m_pos, m_ptr, m_owner, m_tick, m_sec;
  logic [7:0]      m_pay;
  logic [NREQ-1:0] m_gnt;

  task automatic m_reset();
    m_active = 0; m_pend = 0; m_drop = 0; m_done = 0;
    m_pos = 0; m_ptr = 0; m_owner = 0; m_tick = 0; m_sec = 0;
    m_pay = '0; m_gnt = '0;
  endtask

  task automatic m_step();
    bit old_pend, consume;
    old_pend = m_pend;
    consume  = 0;
    m_gnt = '0; m_done = 0; m_drop = 0;
    if (!m_active) begin
      if (old_pend) begin
        m_active = 1; m_pos = 0; m_pay = 8'(m_sec); m_owner = 7; consume = 1;
      end else begin
        for (int j = 0; j < NREQ; j++) begin
          int k;
          k = (m_ptr + j) % NREQ;
          if (req[k]) begin
            m_active = 1; m_pos = 0; m_pay = req_data[k*8 +: 8];
            m_owner = k; m_gnt[k] = 1'b1; m_ptr = (k + 1) % NREQ;
            break;
          end
        end
      end
    end else if (m_pos == FRAME - 1) begin
      m_active = 0; m_done = 1;
    end else begin
      m_pos++;
    end
    if (!sync_en) begin
      m_tick = 0; m_pend = 0;
    end else if (m_tick == SEC - 1) begin
      m_tick = 0; m_sec = (m_sec + 1) % 256; m_drop = old_pend; m_pend = 1;
    end else begin
      m_tick++;
      if (consume) m_pend = 0;
    end
  endtask

  function automatic logic exp_line();
    if (!m_active) return 1'b0;
    if (m_pos < PRE) return 1'b1;
    if (m_pos < PRE + 8 * BITC) return m_pay[7 - (m_pos - PRE) / BITC];
    return 1'b0;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_10M or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_10M);
      if (rst_n) begin
        chk("line",       data_to_slave, exp_line());
        chk("gnt",        gnt,           m_gnt);
        chk("busy",       busy,          m_active);
        chk("frame_done", frame_done,    m_done);
        chk("owner",      owner,         m_owner);
        chk("sec_cnt",    sec_cnt,       m_sec);
        chk("sync_drop",  sync_drop,     m_drop);
        if (sync_drop) n_drop_obs++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_10M);
  endtask

  task automatic do_reset();
    @(negedge clk_10M);
    rst_n = 1'b0; req = '0; sync_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int idx, input int budget, output int cycles);
    cycles = 0;
    while (!gnt[idx] && cycles < budget) begin
      @(negedge clk_10M);
      cycles++;
    end
  endtask

  task automatic wait_any_gnt(input int budget, output int idx);
    int c;
    c = 0;
    idx = -1;
    while (gnt == '0 && c < budget) begin
      @(negedge clk_10M);
      c++;
    end
    for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
  endtask

  int cyc = 0;
  always @(posedge clk_10M) cyc <= cyc + 1;

  initial begin
    logic [52:0] a5_wave;
    logic [7:0]  bcast;
    int          rr_exp [5];
    int          c, idx, last_cyc;

    a5_wave = 53'b111_11111_00000_11111_00000_00000_11111_00000_11111_0000000000;
    rr_exp  = '{0, 1, 2, 3, 0};

    // Single requester, payload 0xA5.
    do_reset();
    chk("rst_line",  data_to_slave, 1'b0);
    chk("rst_gnt",   gnt,           4'b0000);
    chk("rst_busy",  busy,          1'b0);
    chk("rst_owner", owner,         3'd0);
    chk("rst_sec",   sec_cnt,       8'd0);
    req_data[23:16] = 8'hA5;
    req[2] = 1'b1;
    wait_gnt(2, 10, c);
    chk("single_gnt_latency", c, 1);
    chk("single_gnt_onehot", gnt, 4'b0100);
    req[2] = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      chk("single_wave", data_to_slave, a5_wave[FRAME - 1 - p]);
      if (p == 1) chk("single_gnt_pulse", gnt, 4'b0000);
      @(negedge clk_10M);
    end
    chk("single_done",  frame_done, 1'b1);
    chk("single_owner", owner,      3'd2);
    chk("single_idle",  busy,       1'b0);

    // Round robin with all four requesters held.
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_any_gnt(FRAME + 10, idx);
      chk("rr_order", idx, rr_exp[g]);
      if (g > 0) chk("rr_gap", cyc - last_cyc, FRAME + 1);
      last_cyc = cyc;
      @(negedge clk_10M);
    end
    req = '0;
    tick(FRAME + 2);

    // Tick arriving together with req[1]: broadcast of sec_cnt=1 goes first.
    do_reset();
    sync_en = 1'b1;
    c = 0;
    while (sec_cnt == 8'd0 && c < SEC + 10) begin
      @(negedge clk_10M);
      c++;
    end
    chk("prio_sec", sec_cnt, 8'd1);
    req_data[15:8] = 8'h5C;
    req[1] = 1'b1;
    @(negedge clk_10M);
    chk("prio_busy",  busy,  1'b1);
    chk("prio_owner", owner, OWNER_SYNC);
    chk("prio_nognt", gnt,   4'b0000);
    sync_en = 1'b0;
    tick(PRE + 2);
    for (int b = 0; b < 8; b++) begin
      bcast[7 - b] = data_to_slave;
      tick(BITC);
    end
    chk("prio_payload", bcast, 8'd1);
    wait_gnt(1, FRAME + 10, c);
    chk("prio_req1_gnt", gnt[1], 1'b1);
    req[1] = 1'b0;
    @(negedge clk_10M);
    chk("prio_req1_owner", owner, 3'd1);
    tick(FRAME + 2);

    // Overflow: ticks faster than frames, sec_cnt wrap after 256 ticks.
    do_reset();
    n_drop_obs = 0;
    req_data = {8'h9A, 8'h3C, 8'hE1, 8'h07};
    req = 4'hF;
    sync_en = 1'b1;
    c = 0;
    while (sec_cnt != 8'd255 && c < 256 * SEC + 100) begin
      @(negedge clk_10M);
      c++;
    end
    chk("ovf_reach255", sec_cnt, 8'd255);
    c = 0;
    while (sec_cnt == 8'd255 && c < SEC + 10) begin
      @(negedge clk_10M);
      c++;
    end
    chk("ovf_wrap", sec_cnt, 8'd0);
    chk("ovf_drop_seen", (n_drop_obs > 0), 1'b1);
    req = '0;
    sync_en = 1'b0;
    tick(FRAME + 2);

    // Reset in the middle of data bit 4.
    do_reset();
    req_data[7:0] = 8'hFF;
    req[0] = 1'b1;
    wait_gnt(0, 10, c);
    chk("rstmid_gnt", gnt[0], 1'b1);
    tick(PRE + 4 * BITC + 2);
    chk("rstmid_line_hi", data_to_slave, 1'b1);
    #10 rst_n = 1'b0;
    #1;
    chk("rstmid_line_lo", data_to_slave, 1'b0);
    chk("rstmid_busy",    busy,          1'b0);
    chk("rstmid_done",    frame_done,    1'b0);
    tick(3);
    chk("rstmid_hold_done", frame_done, 1'b0);
    chk("rstmid_hold_gnt",  gnt,        4'b0000);
    rst_n = 1'b1;
    wait_gnt(0, 5, c);
    chk("rstmid_regnt_latency", c, 1);
    chk("rstmid_regnt", gnt, 4'b0001);
    req = '0;
    tick(FRAME + 2);

    // Random phase, checked by the per-cycle model.
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk_10M);
      if (t % 200 == 0) sync_en = $urandom_range(0, 1);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req_data[i*8 +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    sync_en = 1'b0;
    tick(FRAME + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
